// File: rtl/locker_pkg.sv
// locker_pkg: shared types and constants for the locker controller.
//   state_e        : controller state, encoded to match the state_o port
//   KEY_CLR/KEY_ENT: keypad control codes (clear / enter)
//   ANGLE_*_DEF    : default servo angles for the closed and open positions
package locker_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_LOCKOUT = 3'd3
    } state_e;

    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_ENT = 4'hB;

    localparam logic [7:0] ANGLE_LOCK_DEF = 8'd90;
    localparam logic [7:0] ANGLE_OPEN_DEF = 8'd40;

endpackage

// File: rtl/locker_entry_buf.sv
// locker_entry_buf: 4-digit BCD entry buffer with digit counter and compare.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : empty the buffer (wins over shift)
//   shift     : shift digit in at [3:0]; dropped once 4 digits are held
//   digit     : BCD digit to shift in
//   pw        : password to compare against
//   entry     : buffer contents, first digit ends up in [15:12]
//   digit_cnt : digits currently held (0..4)
//   full      : digit_cnt == 4
//   match     : full and entry == pw
module locker_entry_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift,
    input  logic [3:0]  digit,
    input  logic [15:0] pw,
    output logic [15:0] entry,
    output logic [2:0]  digit_cnt,
    output logic        full,
    output logic        match
);

    logic [15:0] entry_q, entry_d;
    logic [2:0]  cnt_q, cnt_d;

    always_comb begin
        entry_d = entry_q;
        cnt_d   = cnt_q;
        if (clr) begin
            entry_d = '0;
            cnt_d   = '0;
        end else if (shift && (cnt_q < 3'd4)) begin
            entry_d = {entry_q[11:0], digit};
            cnt_d   = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
            cnt_q   <= '0;
        end else begin
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign entry     = entry_q;
    assign digit_cnt = cnt_q;
    assign full      = (cnt_q == 3'd4);
    assign match     = full && (entry_q == pw);

endmodule

// File: rtl/locker_ctrl.sv
// locker_ctrl: keypad sequencing controller for the digital locker.
// Collects a 4-digit code, checks it against the password, counts failures,
// enforces a lockout and drives the servo angle with a timed auto-relock.
// Build option: define PW_CHANGE_EN to allow changing the password while OPEN
// (otherwise the password is the constant PW_DEFAULT).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   key_valid     : one-cycle key strobe, key_code valid in the same cycle
//   key_code      : 0-9 digit, A clear, B enter, other codes ignored
//   rotate_angle  : servo angle command
//   unlock_pulse  : high during the CHECK cycle that matched
//   err_pulse     : high during the CHECK cycle that failed
//   locked_out    : high while in LOCKOUT
//   fail_cnt      : consecutive failure count
//   digit_cnt     : digits buffered (0..4)
//   state_o       : IDLE=0, CHECK=1, OPEN=2, LOCKOUT=3
module locker_ctrl
    import locker_pkg::*;
#(
    parameter logic [15:0] PW_DEFAULT = 16'h1234,
    parameter int unsigned T_OPEN     = 60_000_000,
    parameter int unsigned T_LOCKOUT  = 300_000_000,
    parameter int unsigned MAX_FAIL   = 3,
    parameter logic [7:0]  ANGLE_LOCK = ANGLE_LOCK_DEF,
    parameter logic [7:0]  ANGLE_OPEN = ANGLE_OPEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] rotate_angle,
    output logic       unlock_pulse,
    output logic       err_pulse,
    output logic       locked_out,
    output logic [1:0] fail_cnt,
    output logic [2:0] digit_cnt,
    output logic [2:0] state_o
);

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  fail_q, fail_d;
    logic [7:0]  angle_q, angle_d;

    logic        buf_clr, buf_shift, buf_full, buf_match;
    logic [15:0] entry, pw;
    logic        pw_wr;

    logic is_digit, is_clr, is_ent, open_expired, lock_expired;

    assign is_digit     = key_valid && (key_code <= 4'd9);
    assign is_clr       = key_valid && (key_code == KEY_CLR);
    assign is_ent       = key_valid && (key_code == KEY_ENT);
    assign open_expired = (timer_q == 32'(T_OPEN - 1));
    assign lock_expired = (timer_q == 32'(T_LOCKOUT - 1));

`ifdef PW_CHANGE_EN
    logic [15:0] pw_q, pw_d;

    always_comb begin
        pw_d = pw_q;
        if (pw_wr) pw_d = entry;
    end

    always_ff @(posedge clk) begin
        if (rst) pw_q <= PW_DEFAULT;
        else     pw_q <= pw_d;
    end

    assign pw = pw_q;
`else
    logic [15:0] unused_entry;
    logic        unused_pw_wr;
    assign unused_entry = entry;
    assign unused_pw_wr = pw_wr;
    assign pw           = PW_DEFAULT;
`endif

    locker_entry_buf u_entry_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (buf_clr),
        .shift     (buf_shift),
        .digit     (key_code),
        .pw        (pw),
        .entry     (entry),
        .digit_cnt (digit_cnt),
        .full      (buf_full),
        .match     (buf_match)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = '0;
        fail_d       = fail_q;
        angle_d      = angle_q;
        buf_clr      = 1'b0;
        buf_shift    = 1'b0;
        pw_wr        = 1'b0;
        unlock_pulse = 1'b0;
        err_pulse    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_digit)     buf_shift = 1'b1;
                else if (is_clr)  buf_clr   = 1'b1;
                else if (is_ent)  state_d   = S_CHECK;
            end

            S_CHECK: begin
                buf_clr = 1'b1;
                if (buf_match) begin
                    unlock_pulse = 1'b1;
                    fail_d       = '0;
                    angle_d      = ANGLE_OPEN;
                    state_d      = S_OPEN;
                end else begin
                    err_pulse = 1'b1;
                    if ((int'(fail_q) + 1) == int'(MAX_FAIL)) begin
                        fail_d  = 2'(MAX_FAIL);
                        state_d = S_LOCKOUT;
                    end else begin
                        fail_d  = fail_q + 2'd1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_OPEN: begin
                timer_d = timer_q + 32'd1;
                // Expiry is checked first so an enter key on the last cycle
                // collapses into the single timed exit. Any partial entry is
                // dropped on relock.
                if (open_expired) begin
                    angle_d = ANGLE_LOCK;
                    buf_clr = 1'b1;
                    state_d = S_IDLE;
                end else if (is_ent) begin
`ifdef PW_CHANGE_EN
                    if (buf_full) begin
                        pw_wr   = 1'b1;
                        buf_clr = 1'b1;
                        timer_d = '0;
                    end else begin
                        angle_d = ANGLE_LOCK;
                        buf_clr = 1'b1;
                        state_d = S_IDLE;
                    end
`else
                    angle_d = ANGLE_LOCK;
                    buf_clr = 1'b1;
                    state_d = S_IDLE;
`endif
                end
`ifdef PW_CHANGE_EN
                else if (is_digit) buf_shift = 1'b1;
                else if (is_clr)   buf_clr   = 1'b1;
`endif
            end

            S_LOCKOUT: begin
                timer_d = timer_q + 32'd1;
                if (lock_expired) begin
                    fail_d  = '0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            fail_q  <= '0;
            angle_q <= ANGLE_LOCK;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            angle_q <= angle_d;
        end
    end

    assign rotate_angle = angle_q;
    assign locked_out   = (state_q == S_LOCKOUT);
    assign fail_cnt     = fail_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_locker_ctrl.sv
module tb_locker_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [7:0] rotate_angle;
    logic       unlock_pulse, err_pulse, locked_out;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt, state_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    locker_ctrl #(
        .T_OPEN    (20),
        .T_LOCKOUT (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .rotate_angle (rotate_angle),
        .unlock_pulse (unlock_pulse),
        .err_pulse    (err_pulse),
        .locked_out   (locked_out),
        .fail_cnt     (fail_cnt),
        .digit_cnt    (digit_cnt),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        step();
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Enter 1,2,3,4,B and advance into the first OPEN cycle (timer = 0).
    task automatic unlock_seq();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
        step();
    endtask

    // Enter 1,2,3,5,B and advance past the CHECK cycle.
    task automatic fail_seq();
        press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(4'hB);
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (state_o !== 3'd0) $display("FAIL rst_state got=%0d exp=0", state_o); else pass_cnt++;
        total_cnt++; if (rotate_angle !== 8'd90) $display("FAIL rst_angle got=%0d exp=90", rotate_angle); else pass_cnt++;
        total_cnt++; if (fail_cnt !== 2'd0) $display("FAIL rst_fail got=%0d exp=0", fail_cnt); else pass_cnt++;
        total_cnt++; if (digit_cnt !== 3'd0) $display("FAIL rst_digits got=%0d exp=0", digit_cnt); else pass_cnt++;
        total_cnt++; if ({unlock_pulse, err_pulse, locked_out} !== 3'b000)
            $display("FAIL rst_flags got=%b exp=000", {unlock_pulse, err_pulse, locked_out}); else pass_cnt++;
    endtask

    task automatic test_unlock();
        int n;
        do_reset();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        total_cnt++; if (digit_cnt !== 3'd4) $display("FAIL t1_digits got=%0d exp=4", digit_cnt); else pass_cnt++;
        press(4'hB);
        total_cnt++; if (state_o !== 3'd1) $display("FAIL t1_check_state got=%0d exp=1", state_o); else pass_cnt++;
        total_cnt++; if (unlock_pulse !== 1'b1) $display("FAIL t1_unlock got=%b exp=1", unlock_pulse); else pass_cnt++;
        total_cnt++; if (err_pulse !== 1'b0) $display("FAIL t1_err got=%b exp=0", err_pulse); else pass_cnt++;
        step();
        total_cnt++; if (state_o !== 3'd2) $display("FAIL t1_open_state got=%0d exp=2", state_o); else pass_cnt++;
        total_cnt++; if (unlock_pulse !== 1'b0) $display("FAIL t1_unlock_width got=%b exp=0", unlock_pulse); else pass_cnt++;
        total_cnt++; if (digit_cnt !== 3'd0) $display("FAIL t1_digits_clr got=%0d exp=0", digit_cnt); else pass_cnt++;
        n = 0;
        while (rotate_angle == 8'd40 && n < 100) begin
            n++;
            step();
        end
        total_cnt++; if (n != 20) $display("FAIL t1_open_dwell got=%0d exp=20", n); else pass_cnt++;
        total_cnt++; if (rotate_angle !== 8'd90) $display("FAIL t1_relock_angle got=%0d exp=90", rotate_angle); else pass_cnt++;
        total_cnt++; if (state_o !== 3'd0) $display("FAIL t1_relock_state got=%0d exp=0", state_o); else pass_cnt++;
    endtask

    task automatic test_lockout();
        int n;
        do_reset();
        press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(4'hB);
        total_cnt++; if (err_pulse !== 1'b1) $display("FAIL t2_err1 got=%b exp=1", err_pulse); else pass_cnt++;
        total_cnt++; if (unlock_pulse !== 1'b0) $display("FAIL t2_unlock1 got=%b exp=0", unlock_pulse); else pass_cnt++;
        step();
        total_cnt++; if (fail_cnt !== 2'd1) $display("FAIL t2_fail1 got=%0d exp=1", fail_cnt); else pass_cnt++;
        total_cnt++; if (state_o !== 3'd0) $display("FAIL t2_state1 got=%0d exp=0", state_o); else pass_cnt++;
        fail_seq();
        total_cnt++; if (fail_cnt !== 2'd2) $display("FAIL t2_fail2 got=%0d exp=2", fail_cnt); else pass_cnt++;
        press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(4'hB);
        total_cnt++; if (err_pulse !== 1'b1) $display("FAIL t2_err3 got=%b exp=1", err_pulse); else pass_cnt++;
        step();
        total_cnt++; if (state_o !== 3'd3) $display("FAIL t2_lock_state got=%0d exp=3", state_o); else pass_cnt++;
        total_cnt++; if (fail_cnt !== 2'd3) $display("FAIL t2_lock_fail got=%0d exp=3", fail_cnt); else pass_cnt++;
        n = locked_out ? 1 : 0;
        // Correct code during lockout must be ignored.
        press(4'd1); if (locked_out) n++;
        press(4'd2); if (locked_out) n++;
        press(4'd3); if (locked_out) n++;
        press(4'd4); if (locked_out) n++;
        total_cnt++; if (digit_cnt !== 3'd0) $display("FAIL t2_keys_ignored got=%0d exp=0", digit_cnt); else pass_cnt++;
        press(4'hB); if (locked_out) n++;
        while (locked_out && n < 200) begin
            step();
            if (locked_out) n++;
        end
        total_cnt++; if (n != 50) $display("FAIL t2_lock_dwell got=%0d exp=50", n); else pass_cnt++;
        total_cnt++; if (fail_cnt !== 2'd0) $display("FAIL t2_fail_clr got=%0d exp=0", fail_cnt); else pass_cnt++;
        total_cnt++; if (state_o !== 3'd0) $display("FAIL t2_exit_state got=%0d exp=0", state_o); else pass_cnt++;
    endtask

    task automatic test_short_entry();
        do_reset();
        press(4'd1); press(4'd2); press(4'hB);
        total_cnt++; if (err_pulse !== 1'b1) $display("FAIL t3_short_err got=%b exp=1", err_pulse); else pass_cnt++;
        step();
        total_cnt++; if (fail_cnt !== 2'd1) $display("FAIL t3_fail1 got=%0d exp=1", fail_cnt); else pass_cnt++;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        total_cnt++; if (digit_cnt !== 3'd4) $display("FAIL t3_saturate got=%0d exp=4", digit_cnt); else pass_cnt++;
        press(4'hB);
        total_cnt++; if (unlock_pulse !== 1'b1) $display("FAIL t3_unlock got=%b exp=1", unlock_pulse); else pass_cnt++;
        step();
        total_cnt++; if (fail_cnt !== 2'd0) $display("FAIL t3_fail_clr got=%0d exp=0", fail_cnt); else pass_cnt++;
        total_cnt++; if (state_o !== 3'd2) $display("FAIL t3_open got=%0d exp=2", state_o); else pass_cnt++;
    endtask

    task automatic test_clear_relock();
        do_reset();
        press(4'd9); press(4'hA);
        total_cnt++; if (digit_cnt !== 3'd0) $display("FAIL t4_clear got=%0d exp=0", digit_cnt); else pass_cnt++;
        press(4'hE);
        total_cnt++; if (digit_cnt !== 3'd0) $display("FAIL t4_undef_key got=%0d exp=0", digit_cnt); else pass_cnt++;
        unlock_seq();
        total_cnt++; if (rotate_angle !== 8'd40) $display("FAIL t4_open_angle got=%0d exp=40", rotate_angle); else pass_cnt++;
        repeat (4) step();
        press(4'd7);
`ifdef PW_CHANGE_EN
        total_cnt++; if (digit_cnt !== 3'd1) $display("FAIL t4_open_digit got=%0d exp=1", digit_cnt); else pass_cnt++;
`else
        total_cnt++; if (digit_cnt !== 3'd0) $display("FAIL t4_open_digit got=%0d exp=0", digit_cnt); else pass_cnt++;
`endif
        total_cnt++; if (state_o !== 3'd2) $display("FAIL t4_still_open got=%0d exp=2", state_o); else pass_cnt++;
        press(4'hB);
        total_cnt++; if (rotate_angle !== 8'd90) $display("FAIL t4_b_relock got=%0d exp=90", rotate_angle); else pass_cnt++;
        total_cnt++; if (state_o !== 3'd0) $display("FAIL t4_b_state got=%0d exp=0", state_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        unlock_seq();
        repeat (19) step();
        total_cnt++; if (rotate_angle !== 8'd40) $display("FAIL t5_last_open got=%0d exp=40", rotate_angle); else pass_cnt++;
        press(4'hB);
        total_cnt++; if (state_o !== 3'd0) $display("FAIL t5_collide_state got=%0d exp=0", state_o); else pass_cnt++;
        total_cnt++; if (rotate_angle !== 8'd90) $display("FAIL t5_collide_angle got=%0d exp=90", rotate_angle); else pass_cnt++;
        step();
        total_cnt++; if (state_o !== 3'd0) $display("FAIL t5_no_double got=%0d exp=0", state_o); else pass_cnt++;
        total_cnt++; if (err_pulse !== 1'b0) $display("FAIL t5_no_err got=%b exp=0", err_pulse); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        unlock_seq();
        repeat (10) step();
        press(4'd3);
        do_reset();
        total_cnt++; if (state_o !== 3'd0) $display("FAIL t6_open_rst_state got=%0d exp=0", state_o); else pass_cnt++;
        total_cnt++; if (rotate_angle !== 8'd90) $display("FAIL t6_open_rst_angle got=%0d exp=90", rotate_angle); else pass_cnt++;
        total_cnt++; if (digit_cnt !== 3'd0) $display("FAIL t6_open_rst_digits got=%0d exp=0", digit_cnt); else pass_cnt++;
        fail_seq(); fail_seq(); fail_seq();
        total_cnt++; if (locked_out !== 1'b1) $display("FAIL t6_in_lockout got=%b exp=1", locked_out); else pass_cnt++;
        repeat (30) step();
        do_reset();
        total_cnt++; if (state_o !== 3'd0) $display("FAIL t6_lock_rst_state got=%0d exp=0", state_o); else pass_cnt++;
        total_cnt++; if (locked_out !== 1'b0) $display("FAIL t6_lock_rst_flag got=%b exp=0", locked_out); else pass_cnt++;
        total_cnt++; if (fail_cnt !== 2'd0) $display("FAIL t6_lock_rst_fail got=%0d exp=0", fail_cnt); else pass_cnt++;
        total_cnt++; if (rotate_angle !== 8'd90) $display("FAIL t6_lock_rst_angle got=%0d exp=90", rotate_angle); else pass_cnt++;
    endtask

`ifdef PW_CHANGE_EN
    task automatic test_pw_change();
        int n;
        do_reset();
        unlock_seq();
        repeat (10) step();
        press(4'd5); press(4'd6); press(4'd7); press(4'd8);
        press(4'hB);
        total_cnt++; if (state_o !== 3'd2) $display("FAIL t7_stay_open got=%0d exp=2", state_o); else pass_cnt++;
        total_cnt++; if (digit_cnt !== 3'd0) $display("FAIL t7_buf_clr got=%0d exp=0", digit_cnt); else pass_cnt++;
        n = 1;
        while (rotate_angle == 8'd40 && n < 100) begin
            step();
            if (rotate_angle == 8'd40) n++;
        end
        total_cnt++; if (n != 20) $display("FAIL t7_timer_restart got=%0d exp=20", n); else pass_cnt++;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
        total_cnt++; if (err_pulse !== 1'b1) $display("FAIL t7_old_pw got=%b exp=1", err_pulse); else pass_cnt++;
        step();
        press(4'd5); press(4'd6); press(4'd7); press(4'd8); press(4'hB);
        total_cnt++; if (unlock_pulse !== 1'b1) $display("FAIL t7_new_pw got=%b exp=1", unlock_pulse); else pass_cnt++;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_short_entry();
        test_clear_relock();
        test_back_to_back();
        test_reset_mid();
`ifdef PW_CHANGE_EN
        test_pw_change();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
